// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution datapath.
// Window geometry helpers used by the window generator and the conv core.
package conv_pkg;

  localparam int COL       = 3;
  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 2*IN_WIDTH + $clog2(COL*COL);

  typedef logic [IN_WIDTH-1:0] pixel_t;

  function automatic int win_idx(
    input int i,
    input int j,
    input int col = COL
  );
    return i*col + j;
  endfunction

endpackage

// File: rtl/conv_line_delay.sv
// One image row of delay: column-addressed RAM, read-before-write.
// dout is the value stored at addr one row ago.
module conv_line_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) r_mem[i_addr] <= i_din;
  end

  assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to COL x COL sliding window, valid-only.
// One-cycle latency from accepted pixel to window_valid.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int COL      = conv_pkg::COL,
  parameter int IN_WIDTH = conv_pkg::IN_WIDTH,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sof,
  input  logic                         pixel_valid,
  input  logic [IN_WIDTH-1:0]          pixel,
  output logic [COL*COL*IN_WIDTH-1:0]  window,
  output logic                         window_valid,
  output logic                         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = COL*COL*IN_WIDTH;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win_ok;
  logic          w_emit;

  logic [IN_WIDTH-1:0] w_tap [COL];
  logic [IN_WIDTH-1:0] r_sh  [COL][COL];
  logic [IN_WIDTH-1:0] w_sh  [COL][COL];
  logic [WW-1:0]       w_flat;

  logic [WW-1:0] r_window;
  logic          r_valid;
  logic          r_done;

  // sof forces this pixel to (0,0) so counters resync mid-frame
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_col_last = (w_col == CW'(IMG_W-1));
    w_row_last = (w_row == RW'(IMG_H-1));
    w_col_nxt  = w_col_last ? '0 : w_col + CW'(1);
    w_row_nxt  = w_row;
    if (w_col_last) begin
      w_row_nxt = w_row_last ? '0 : w_row + RW'(1);
    end
    w_win_ok = (w_row >= RW'(COL-1)) &&
               (w_col >= CW'(COL-1));
    w_emit   = pixel_valid && w_win_ok;
  end

  assign w_tap[0] = pixel;

  for (genvar k = 0; k < COL-1; k++) begin : g_line
    conv_line_delay #(
      .W     (IN_WIDTH),
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_line (
      .clk    (clk),
      .i_en   (pixel_valid),
      .i_addr (w_col),
      .i_din  (w_tap[k]),
      .o_dout (w_tap[k+1])
    );
  end

  // Row 0 of the window is the oldest row, i.e. the deepest tap
  always_comb begin
    for (int i = 0; i < COL; i++) begin
      for (int j = 0; j < COL; j++) begin
        if (j < COL-1) w_sh[i][j] = r_sh[i][j+1];
        else           w_sh[i][j] = w_tap[COL-1-i];
      end
    end
  end

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < COL; i++) begin
      for (int j = 0; j < COL; j++) begin
        w_flat[win_idx(i, j, COL)*IN_WIDTH +: IN_WIDTH] = w_sh[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
      for (int i = 0; i < COL; i++) begin
        for (int j = 0; j < COL; j++) begin
          r_sh[i][j] <= '0;
        end
      end
    end else if (pixel_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_sh  <= w_sh;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_window <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_done  <= w_emit && w_row_last && w_col_last;
      if (w_emit) r_window <= w_flat;
    end
  end

  assign window       = r_window;
  assign window_valid = r_valid;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen, 5x5 image, 3x3 window.
// Pixel value r*5+c+base; expected windows built from that formula.
module tb_conv_window_gen;

  localparam int COL = 3;
  localparam int IW  = 8;
  localparam int W   = 5;
  localparam int H   = 5;
  localparam int WW  = COL*COL*IW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sof = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [IW-1:0] pixel = '0;
  logic [WW-1:0] window;
  logic          window_valid;
  logic          frame_done;

  int n_checks = 0;
  int n_errs   = 0;
  int n_win    = 0;
  int n_fd     = 0;
  logic [WW-1:0] exp_win = '0;
  logic [WW-1:0] first_win;
  logic [WW-1:0] last_win;
  logic          got_first;

  conv_window_gen #(
    .COL      (COL),
    .IN_WIDTH (IW),
    .IMG_W    (W),
    .IMG_H    (H)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sof          (sof),
    .pixel_valid  (pixel_valid),
    .pixel        (pixel),
    .window       (window),
    .window_valid (window_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkwin(
    input int r, input int c, input int base
  );
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < COL; i++)
      for (int j = 0; j < COL; j++)
        w[(i*COL+j)*IW +: IW] =
          IW'(base + (r-COL+1+i)*W + (c-COL+1+j));
    return w;
  endfunction

  function automatic logic [WW-1:0] pk9(
    input int a0, a1, a2, a3, a4, a5, a6, a7, a8
  );
    int a [9];
    logic [WW-1:0] w;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*IW +: IW] = IW'(a[k]);
    return w;
  endfunction

  task automatic step(
    input logic v, input logic s,
    input int r, input int c, input int base
  );
    logic ev, ef;
    sof         = s;
    pixel_valid = v;
    pixel       = IW'(base + r*W + c);
    @(posedge clk);
    #1;
    ev = v && (r >= COL-1) && (c >= COL-1);
    ef = ev && (r == H-1) && (c == W-1);
    if (ev) begin
      exp_win = mkwin(r, c, base);
      n_win++;
    end
    chk("window_valid", 128'(window_valid), 128'(ev));
    chk("window", 128'(window), 128'(exp_win));
    chk("frame_done", 128'(frame_done), 128'(ef));
    if (frame_done) n_fd++;
    if (window_valid && !got_first) begin
      first_win = window;
      got_first = 1'b1;
    end
    if (window_valid) last_win = window;
  endtask

  task automatic frame(input int base, input logic bub);
    got_first = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (bub) step(1'b0, 1'b1, r, c, base);
        step(1'b1, (r == 0 && c == 0), r, c, base);
      end
    sof = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic partial(input int n, input int base);
    for (int k = 0; k < n; k++)
      step(1'b1, (k == 0), k / W, k % W, base);
    sof = 1'b0;
    pixel_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_window", 128'(window), 128'(0));
    chk("reset_valid", 128'(window_valid), 128'(0));
    chk("reset_done", 128'(frame_done), 128'(0));
    @(negedge clk);
    rstn = 1'b1;

    n_win = 0; n_fd = 0;
    frame(0, 1'b0);
    chk("t1_count", 128'(n_win), 128'(9));
    chk("t1_fd", 128'(n_fd), 128'(1));
    chk("t1_first", 128'(first_win), 128'(pk9(0,1,2,5,6,7,10,11,12)));
    chk("t1_last", 128'(last_win), 128'(pk9(12,13,14,17,18,19,22,23,24)));

    n_win = 0; n_fd = 0;
    frame(0, 1'b1);
    chk("t2_count", 128'(n_win), 128'(9));
    chk("t2_fd", 128'(n_fd), 128'(1));
    chk("t2_first", 128'(first_win), 128'(pk9(0,1,2,5,6,7,10,11,12)));

    n_win = 0;
    partial(8, 0);
    chk("t4_old_windows", 128'(n_win), 128'(0));
    frame(100, 1'b0);
    chk("t4_count", 128'(n_win), 128'(9));
    chk("t4_first", 128'(first_win),
        128'(pk9(100,101,102,105,106,107,110,111,112)));

    partial(14, 0);
    chk("t5_pre_valid", 128'(window_valid), 128'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_window", 128'(window), 128'(0));
    chk("t5_rst_valid", 128'(window_valid), 128'(0));
    exp_win = '0;
    @(negedge clk);
    rstn = 1'b1;
    n_win = 0; n_fd = 0;
    frame(0, 1'b0);
    chk("t5_count", 128'(n_win), 128'(9));
    chk("t5_last", 128'(last_win), 128'(pk9(12,13,14,17,18,19,22,23,24)));

    n_win = 0; n_fd = 0;
    frame(0, 1'b0);
    frame(50, 1'b0);
    chk("t6_count", 128'(n_win), 128'(18));
    chk("t6_fd", 128'(n_fd), 128'(2));
    chk("t6_first2", 128'(first_win),
        128'(pk9(50,51,52,55,56,57,60,61,62)));

    @(posedge clk);
    #1;
    chk("idle_valid", 128'(window_valid), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
